// File: rtl/ss_pkg.sv
// Shared definitions for the shift-register sequencer: FSM state encoding and default word width.
package ss_pkg;

  localparam int unsigned SsWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDrain,
    StResp
  } ss_state_e;

endpackage

// File: rtl/ss_rr_arbiter.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie, req0 after reset.
module ss_rr_arbiter (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic gnt_o,
  output logic gnt_id_o
);

  // prio_q names the requester that wins when both are requesting
  logic prio_q, prio_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (en_i) begin
      if (req0_i && req1_i) begin
        gnt0_o = ~prio_q;
        gnt1_o = prio_q;
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  assign gnt_o    = gnt0_o | gnt1_o;
  assign gnt_id_o = gnt1_o;

  always_comb begin
    prio_d = prio_q;
    if (gnt_o) begin
      prio_d = gnt0_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ss_shift_sequencer.sv
// Serializes an arbitrated word into an external serial shift register, drains it back and
// reports the returned word together with a match flag.
module ss_shift_sequencer
  import ss_pkg::*;
#(
  parameter int unsigned WIDTH = SsWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_dir,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_dir,
  output logic             req1_ready,
  output logic             sr_data_in,
  output logic             sr_leri,
  output logic             sr_ena,
  input  logic             sr_data_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_match,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ss_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             dir_q, dir_d;
  logic             id_q, id_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_match_q, rsp_match_d;

  logic             arb_en;
  logic             gnt0, gnt1, gnt, gnt_id;
  logic             cnt_last;
  logic [IdxW-1:0]  cnt_idx;
  logic [IdxW-1:0]  bit_idx;

  // Grants only from IDLE, never while frozen or while reset is asserted.
  assign arb_en = ena && !rst && (state_q == StIdle);

  ss_rr_arbiter u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (arb_en),
    .req0_i   (req0_valid),
    .req1_i   (req1_valid),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign cnt_last = (cnt_q == CntLast);
  assign cnt_idx  = cnt_q[IdxW-1:0];
  // Word bit position of the current step in send order; shared by SEND and DRAIN.
  assign bit_idx  = dir_q ? (IdxW'(WIDTH - 1) - cnt_idx) : cnt_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt) state_d = StSend;
      StSend:  if (cnt_last) state_d = StDrain;
      StDrain: if (cnt_last) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: latch on grant, step the counter, assemble returned bits.
  always_comb begin
    cnt_d       = cnt_q;
    word_d      = word_q;
    dir_d       = dir_q;
    id_d        = id_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_match_d = rsp_match_q;
    unique case (state_q)
      StIdle: begin
        if (gnt) begin
          word_d = gnt_id ? req1_data : req0_data;
          dir_d  = gnt_id ? req1_dir : req0_dir;
          id_d   = gnt_id;
          cnt_d  = '0;
        end
      end
      StSend: begin
        cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
      end
      StDrain: begin
        cnt_d          = cnt_last ? '0 : cnt_q + CntW'(1);
        cap_d[bit_idx] = sr_data_out;
        if (cnt_last) begin
          rsp_data_d  = cap_d;
          rsp_id_d    = id_q;
          rsp_match_d = (cap_d == word_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      word_q      <= '0;
      dir_q       <= 1'b0;
      id_q        <= 1'b0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_match_q <= 1'b0;
    end else if (ena) begin
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      dir_q       <= dir_d;
      id_q        <= id_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_match_q <= rsp_match_d;
    end
  end

  // Output logic
  always_comb begin
    busy       = (state_q != StIdle);
    sr_ena     = 1'b0;
    sr_leri    = 1'b0;
    sr_data_in = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      StSend: begin
        sr_ena     = ena;
        sr_leri    = dir_q;
        sr_data_in = word_q[bit_idx];
      end
      StDrain: begin
        sr_ena  = ena;
        sr_leri = dir_q;
      end
      StResp:  rsp_valid = ena;
      default: ;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_match  = rsp_match_q;

endmodule
